// File: rtl/fc_pkg.sv
// Shared constants, state encoding and output activation for the FC layers.
// All activations are signed Q8.8; accumulators carry the same scale.
package fc_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int PSUM_WIDTH  = 17;
    localparam int ACC_WIDTH   = 24;
    localparam int INPUT_SIZE  = 400;
    localparam int OUTPUT_MAP  = 120;
    localparam int FC2_SIZE    = 84;
    localparam int FC3_SIZE    = 10;
    localparam int CHUNKS      = 25;
    localparam int OUTPUT_SIZE = OUTPUT_MAP * DATA_WIDTH;
    localparam int NRN_W       = 7;
    localparam int CHK_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } fc_state_t;

    // Negative -> 0, anything above 0x7FFF clamps to 0x7FFF.
    function automatic logic [DATA_WIDTH-1:0] sat_relu(
        input logic signed [ACC_WIDTH-1:0] x
    );
        if (x[ACC_WIDTH-1])
            return '0;
        if (|x[ACC_WIDTH-2:DATA_WIDTH-1])
            return 16'h7FFF;
        return x[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sat_relu_q88.sv
// Combinational ReLU with positive saturation, ACC_WIDTH -> Q8.8.
// Shared by the FC and conv output stages.
module sat_relu_q88
    import fc_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0]       y
);

    assign y = sat_relu(x);

endmodule

// File: rtl/fc_accum_relu.sv
// FC1 back end: accumulates 25 chunk partial sums per neuron, adds bias,
// applies saturating ReLU and holds the 120-lane activation vector.
module fc_accum_relu
    import fc_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         psum_valid,
    input  logic signed [PSUM_WIDTH-1:0] psum,
    output logic [NRN_W-1:0]             bias_addr,
    input  logic signed [DATA_WIDTH-1:0] bias_data,
    output logic [OUTPUT_SIZE-1:0]       out,
    output logic                         busy,
    output logic                         fc_done
);

    fc_state_t state, state_nxt;

    logic [NRN_W-1:0]            nrn_cnt;
    logic [CHK_W-1:0]            chk_cnt;
    logic signed [ACC_WIDTH-1:0] acc [OUTPUT_MAP];

    logic signed [ACC_WIDTH-1:0] s1_sum;
    logic [NRN_W-1:0]            s1_idx;
    logic                        s1_vld;

    logic                        accept;
    logic                        nrn_wrap;
    logic                        chk_last;
    logic signed [ACC_WIDTH-1:0] psum_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0]       r_act;

    // A start in ACCUM restarts the pass, so it wins over a coincident psum.
    assign accept   = (state == ST_ACCUM) && psum_valid && !start;
    assign nrn_wrap = (nrn_cnt == NRN_W'(OUTPUT_MAP - 1));
    assign chk_last = (chk_cnt == CHK_W'(CHUNKS - 1));
    assign psum_ext = {{(ACC_WIDTH-PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum};
    assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_data[DATA_WIDTH-1]}}, bias_data};
    assign r_sum    = s1_sum + bias_ext;

    assign bias_addr = nrn_cnt;
    assign busy      = (state == ST_ACCUM);
    assign fc_done   = (state == ST_DONE);

    sat_relu_q88 u_relu (
        .x (r_sum),
        .y (r_act)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_ACCUM;
            ST_ACCUM: begin
                if (start)
                    state_nxt = ST_ACCUM;
                else if (s1_vld && s1_idx == NRN_W'(OUTPUT_MAP - 1))
                    state_nxt = ST_DONE;
            end
            ST_DONE:  if (start) state_nxt = ST_ACCUM;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrn_cnt <= '0;
            chk_cnt <= '0;
        end else if (start) begin
            nrn_cnt <= '0;
            chk_cnt <= '0;
        end else if (accept) begin
            if (nrn_wrap) begin
                nrn_cnt <= '0;
                chk_cnt <= chk_last ? '0 : chk_cnt + 1'b1;
            end else begin
                nrn_cnt <= nrn_cnt + 1'b1;
            end
        end
    end

    // Chunk 0 overwrites, so no clear pass is needed between layers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUTPUT_MAP; i++)
                acc[i] <= '0;
            s1_sum <= '0;
            s1_idx <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= accept && chk_last;
            if (accept) begin
                if (chk_cnt == '0) begin
                    acc[nrn_cnt] <= psum_ext;
                end else if (chk_last) begin
                    s1_sum <= acc[nrn_cnt] + psum_ext;
                    s1_idx <= nrn_cnt;
                end else begin
                    acc[nrn_cnt] <= acc[nrn_cnt] + psum_ext;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out <= '0;
        else if (s1_vld)
            out[int'(s1_idx)*DATA_WIDTH +: DATA_WIDTH] <= r_act;
    end

endmodule

// File: tb/tb_fc_accum_relu.sv
// Self-checking bench for fc_accum_relu: randomized psum streams and biases
// compared lane by lane against a plain-arithmetic reference.
module tb_fc_accum_relu;

    localparam int NRN   = 120;
    localparam int CHK   = 25;
    localparam int TOTAL = NRN * CHK;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               psum_valid;
    logic signed [16:0] psum;
    logic [6:0]         bias_addr;
    logic signed [15:0] bias_data;
    logic [1919:0]      out;
    logic               busy;
    logic               fc_done;

    int stim [TOTAL];
    int bias_rom [128];
    logic [1919:0] saved;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // Synchronous bias ROM: data follows the address by one cycle.
    always @(posedge clk) bias_data <= bias_rom[bias_addr][15:0];

    fc_accum_relu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .psum_valid (psum_valid),
        .psum       (psum),
        .bias_addr  (bias_addr),
        .bias_data  (bias_data),
        .out        (out),
        .busy       (busy),
        .fc_done    (fc_done)
    );

    function automatic logic [15:0] ref_lane(input int n);
        longint s;
        s = bias_rom[n];
        for (int c = 0; c < CHK; c++)
            s += stim[c*NRN + n];
        if (s < 0)
            return 16'h0000;
        if (s > 32767)
            return 16'h7FFF;
        return 16'(s);
    endfunction

    function automatic void fill_const(input int p, input int b);
        for (int i = 0; i < TOTAL; i++) stim[i] = p;
        for (int i = 0; i < 128; i++) bias_rom[i] = b;
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < TOTAL; i++)
            stim[i] = int'($urandom_range(0, 3000)) - 1500;
        for (int i = 0; i < 128; i++)
            bias_rom[i] = int'($urandom_range(0, 8000)) - 4000;
    endfunction

    task automatic check_all(input string name);
        for (int n = 0; n < NRN; n++) begin
            vectors++;
            if (out[n*16 +: 16] !== ref_lane(n)) begin
                errors++;
                $display("FAIL %s lane %0d: got %h expected %h",
                         name, n, out[n*16 +: 16], ref_lane(n));
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start      = 1'b1;
        psum_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_pulses(input int k);
        repeat (k) begin
            @(negedge clk);
            psum_valid = 1'b1;
            psum       = 17'($urandom);
        end
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    // Leaves the last accepted psum driven; caller's next negedge drops it.
    task automatic feed(input int n, input int gap_pct);
        int acc_n = 0;
        int cyc   = 0;
        while (acc_n < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            vectors++;
            if (bias_addr !== 7'(acc_n % NRN)) begin
                errors++;
                $display("FAIL bias_addr after %0d psums: got %0d expected %0d",
                         acc_n, bias_addr, acc_n % NRN);
            end
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                psum_valid = 1'b0;
                psum       = 17'($urandom);
            end else begin
                psum_valid = 1'b1;
                psum       = stim[acc_n][16:0];
                acc_n++;
            end
        end
        if (acc_n < n) begin
            errors++;
            $display("FAIL feed timeout: accepted %0d expected %0d", acc_n, n);
        end
    endtask

    task automatic finish_pass(input string name);
        @(negedge clk);
        psum_valid = 1'b0;
        vectors++;
        if (fc_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_early: fc_done=%b busy=%b expected 0/1",
                     name, fc_done, busy);
        end
        @(negedge clk);
        vectors++;
        if (fc_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_rise: fc_done=%b busy=%b expected 1/0",
                     name, fc_done, busy);
        end
    endtask

    task automatic run_pass(input string name, input int gap_pct, input bit pulses);
        if (pulses) idle_pulses(4);
        do_start();
        feed(TOTAL, gap_pct);
        finish_pass(name);
        check_all(name);
        if (pulses) begin
            idle_pulses(6);
            vectors++;
            if (fc_done !== 1'b1) begin
                errors++;
                $display("FAIL %s done_hold: fc_done=%b expected 1", name, fc_done);
            end
            check_all({name, "_after_pulses"});
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        psum_valid = 1'b0;
        psum       = '0;
        fill_const(0, 0);
        #1;
        vectors++;
        if (out !== '0 || busy !== 1'b0 || fc_done !== 1'b0 || bias_addr !== 7'd0) begin
            errors++;
            $display("FAIL reset: out_nz=%b busy=%b fc_done=%b addr=%0d expected 0",
                     |out, busy, fc_done, bias_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ones();
        fill_const(1, 0);
        run_pass("ones", 0, 1'b0);
        for (int n = 0; n < NRN; n++) begin
            vectors++;
            if (out[n*16 +: 16] !== 16'h0019) begin
                errors++;
                $display("FAIL ones_const lane %0d: got %h expected 0019", n, out[n*16 +: 16]);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        fill_random();
        do_start();
        feed(500, 0);
        @(negedge clk);
        psum_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        vectors++;
        if (out !== '0 || busy !== 1'b0 || fc_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: out_nz=%b busy=%b fc_done=%b expected 0",
                     |out, busy, fc_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_restart_after_reset();
        fill_random();
        run_pass("restart", 0, 1'b1);
    endtask

    task automatic test_neg_bias();
        fill_const(-2, 40);
        run_pass("neg40", 0, 1'b0);
        vectors++;
        if (out !== '0) begin
            errors++;
            $display("FAIL neg40_zero: lane0=%h expected 0000", out[15:0]);
        end
        fill_const(-2, 60);
        run_pass("neg60", 0, 1'b0);
        for (int n = 0; n < NRN; n += 17) begin
            vectors++;
            if (out[n*16 +: 16] !== 16'h000A) begin
                errors++;
                $display("FAIL neg60 lane %0d: got %h expected 000a", n, out[n*16 +: 16]);
            end
        end
    endtask

    task automatic test_saturation();
        fill_const(0, 0);
        for (int c = 0; c < CHK; c++) begin
            stim[c*NRN + 7] = 65535;
            stim[c*NRN + 8] = -65536;
        end
        run_pass("sat", 0, 1'b0);
        vectors++;
        if (out[7*16 +: 16] !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_pos: got %h expected 7fff", out[7*16 +: 16]);
        end
        vectors++;
        if (out[8*16 +: 16] !== 16'h0000) begin
            errors++;
            $display("FAIL sat_neg: got %h expected 0000", out[8*16 +: 16]);
        end
    endtask

    task automatic test_gaps();
        fill_random();
        run_pass("gapfree", 0, 1'b0);
        saved = out;
        run_pass("gaps", 40, 1'b1);
        vectors++;
        if (out !== saved) begin
            errors++;
            $display("FAIL gaps_vs_gapfree: lane0 got %h expected %h", out[15:0], saved[15:0]);
        end
    endtask

    task automatic test_abort();
        fill_random();
        do_start();
        feed(1500, 20);
        do_start();
        vectors++;
        if (busy !== 1'b1 || bias_addr !== 7'd0 || fc_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b addr=%0d fc_done=%b expected 1/0/0",
                     busy, bias_addr, fc_done);
        end
        fill_random();
        feed(TOTAL, 0);
        finish_pass("abort");
        check_all("abort");
    endtask

    initial begin
        test_reset();
        test_ones();
        test_reset_mid_pass();
        test_restart_after_reset();
        test_neg_bias();
        test_saturation();
        test_gaps();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
